// File: rtl/raom_bus_master_if.sv
// Request/response handshake between the CPU control FSM and the RAOM bus master.
// The CPU side uses the master modport; the bus master block uses the slave modport.
interface raom_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [12:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_opcode;
    logic [12:0] rsp_oprnd;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_opcode, rsp_oprnd
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_opcode, rsp_oprnd
    );
endinterface

// File: rtl/raom_bus_master.sv
// CPU-side master for the byte-wide RAOM bus. Serves one request at a time:
// byte read, byte write (setup/strobe/hold) or a 16-bit instruction fetch built
// from two byte reads, and splits fetched words into opcode and operand.
// All outputs come straight from flops; strobes are decoded from the next state.
module raom_bus_master #(
    parameter int unsigned RD_WAIT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    raom_bus_master_if.slave        req_if,
    output logic [12:0]             mem_addr,
    output logic                    mem_read,
    output logic                    mem_write,
    inout  wire  [7:0]              mem_data
);

    localparam int unsigned CW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(RD_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD        = 3'd1,
        S_WR_SETUP  = 3'd2,
        S_WR_STROBE = 3'd3,
        S_WR_HOLD   = 3'd4,
        S_F_B0      = 3'd5,
        S_F_B1      = 3'd6,
        S_RESP      = 3'd7
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     wdata_q, wdata_d;
    logic [7:0]     byte0_q, byte0_d;
    logic           mem_oe_q, mem_oe_d;
    logic [12:0]    mem_addr_q, mem_addr_d;
    logic           mem_read_q, mem_read_d;
    logic           mem_write_q, mem_write_d;
    logic           req_ready_q, req_ready_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [15:0]    rsp_data_q, rsp_data_d;
    logic [2:0]     rsp_opcode_q, rsp_opcode_d;
    logic [12:0]    rsp_oprnd_q, rsp_oprnd_d;

    // Next-state, datapath capture and strobe decode for the bus sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wdata_d      = wdata_q;
        byte0_d      = byte0_q;
        mem_addr_d   = mem_addr_q;
        rsp_data_d   = rsp_data_q;
        rsp_opcode_d = rsp_opcode_q;
        rsp_oprnd_d  = rsp_oprnd_q;

        case (state_q)
            S_IDLE: begin
                if (req_if.req_valid && req_ready_q) begin
                    mem_addr_d = req_if.req_addr;
                    wdata_d    = req_if.req_wdata;
                    cnt_d      = '0;
                    case (req_if.req_op)
                        2'b00:   state_d = S_RD;
                        2'b01:   state_d = S_WR_SETUP;
                        2'b10:   state_d = S_F_B0;
                        default: begin
                            // Reserved op completes immediately with an empty response.
                            state_d    = S_RESP;
                            rsp_data_d = 16'h0000;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (cnt_q == LAST_WAIT) begin
                    rsp_data_d = {8'h00, mem_data};
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_F_B0: begin
                if (cnt_q == LAST_WAIT) begin
                    // Second byte address wraps naturally in 13 bits.
                    byte0_d    = mem_data;
                    mem_addr_d = mem_addr_q + 13'd1;
                    cnt_d      = '0;
                    state_d    = S_F_B1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_F_B1: begin
                if (cnt_q == LAST_WAIT) begin
                    rsp_data_d   = {byte0_q, mem_data};
                    rsp_opcode_d = mem_data[2:0];
                    rsp_oprnd_d  = {byte0_q, mem_data[7:3]};
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WR_SETUP:  state_d = S_WR_STROBE;
            S_WR_STROBE: state_d = S_WR_HOLD;
            S_WR_HOLD: begin
                rsp_data_d = 16'h0000;
                state_d    = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered versions of what the next state requires, so
        // read and write strobes can never be high together.
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        mem_read_d  = (state_d == S_RD) || (state_d == S_F_B0) || (state_d == S_F_B1);
        mem_write_d = (state_d == S_WR_STROBE);
        mem_oe_d    = (state_d == S_WR_SETUP) || (state_d == S_WR_STROBE) ||
                      (state_d == S_WR_HOLD);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wdata_q      <= 8'h00;
            byte0_q      <= 8'h00;
            mem_oe_q     <= 1'b0;
            mem_addr_q   <= 13'h0000;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 16'h0000;
            rsp_opcode_q <= 3'd0;
            rsp_oprnd_q  <= 13'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wdata_q      <= wdata_d;
            byte0_q      <= byte0_d;
            mem_oe_q     <= mem_oe_d;
            mem_addr_q   <= mem_addr_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_opcode_q <= rsp_opcode_d;
            rsp_oprnd_q  <= rsp_oprnd_d;
        end
    end

    assign mem_addr          = mem_addr_q;
    assign mem_read          = mem_read_q;
    assign mem_write         = mem_write_q;
    assign mem_data          = mem_oe_q ? wdata_q : 8'bz;
    assign req_if.req_ready  = req_ready_q;
    assign req_if.rsp_valid  = rsp_valid_q;
    assign req_if.rsp_data   = rsp_data_q;
    assign req_if.rsp_opcode = rsp_opcode_q;
    assign req_if.rsp_oprnd  = rsp_oprnd_q;

endmodule

// File: tb/tb_raom_bus_master.sv
// Directed bench for raom_bus_master: one instance with RD_WAIT=1 and one with
// RD_WAIT=3, each attached to its own behavioural RAOM.
module tb_raom_bus_master;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    raom_bus_master_if bus1();
    raom_bus_master_if bus3();

    logic [12:0] mem_addr1, mem_addr3;
    logic        mem_read1, mem_read3;
    logic        mem_write1, mem_write3;
    wire  [7:0]  mem_data1, mem_data3;

    raom_bus_master #(.RD_WAIT(1)) dut1 (
        .clk(clk), .rst(rst), .req_if(bus1),
        .mem_addr(mem_addr1), .mem_read(mem_read1),
        .mem_write(mem_write1), .mem_data(mem_data1)
    );

    raom_bus_master #(.RD_WAIT(3)) dut3 (
        .clk(clk), .rst(rst), .req_if(bus3),
        .mem_addr(mem_addr3), .mem_read(mem_read3),
        .mem_write(mem_write3), .mem_data(mem_data3)
    );

    // Behavioural RAOMs: drive data while read is enabled, capture on write rising edge.
    logic [7:0]  raom1 [0:8191];
    logic [7:0]  raom3 [0:8191];
    logic        pre_we1, pre_we3;
    logic [12:0] pre_addr;
    logic [7:0]  pre_data;
    logic        mw_prev1, mw_prev3;
    int          wr_edges1, wr_edges3;
    int          overlap;

    assign mem_data1 = mem_read1 ? raom1[mem_addr1] : 8'bz;
    assign mem_data3 = mem_read3 ? raom3[mem_addr3] : 8'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAOM 1 storage: preload port and write-strobe rising-edge capture.
    always @(negedge clk) begin
        if (pre_we1) begin
            raom1[pre_addr] <= pre_data;
        end else if (mem_write1 && !mw_prev1) begin
            raom1[mem_addr1] <= mem_data1;
            wr_edges1        <= wr_edges1 + 1;
        end
        mw_prev1 <= mem_write1;
    end

    // RAOM 3 storage: same behaviour for the slow-read instance.
    always @(negedge clk) begin
        if (pre_we3) begin
            raom3[pre_addr] <= pre_data;
        end else if (mem_write3 && !mw_prev3) begin
            raom3[mem_addr3] <= mem_data3;
            wr_edges3        <= wr_edges3 + 1;
        end
        mw_prev3 <= mem_write3;
    end

    // Count any cycle where read and write strobes overlap on either bus.
    always @(negedge clk) begin
        if ((mem_read1 && mem_write1) || (mem_read3 && mem_write3)) overlap <= overlap + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input bit sel3, input logic [12:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        if (sel3) pre_we3 = 1'b1; else pre_we1 = 1'b1;
        @(negedge clk);
        #1;
        pre_we1 = 1'b0;
        pre_we3 = 1'b0;
        tick();
    endtask

    // Present a request on bus1 for one accept edge; returns in cycle 1.
    task automatic issue1(input logic [1:0] op, input logic [12:0] a, input logic [7:0] d);
        bus1.req_valid = 1'b1;
        bus1.req_op    = op;
        bus1.req_addr  = a;
        bus1.req_wdata = d;
        tick();
        bus1.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus1.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", bus1.req_ready); end
        checks++; if (bus1.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus1.rsp_valid); end
        checks++; if ({bus1.rsp_data, bus1.rsp_opcode, bus1.rsp_oprnd} !== 32'h0) begin errors++; $display("FAIL reset_rsp: got %h/%h/%h expected 0/0/0", bus1.rsp_data, bus1.rsp_opcode, bus1.rsp_oprnd); end
        checks++; if ({mem_addr1, mem_read1, mem_write1} !== 15'h0) begin errors++; $display("FAIL reset_mem: got addr=%h rd=%b wr=%b expected 0/0/0", mem_addr1, mem_read1, mem_write1); end
        checks++; if (bus3.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready3: got %b expected 1", bus3.req_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        poke(1'b0, 13'd2, 8'h09);
        poke(1'b0, 13'd3, 8'h66);
        issue1(2'b10, 13'd2, 8'h00);
        checks++; if ({mem_read1, mem_addr1} !== {1'b1, 13'd2}) begin errors++; $display("FAIL fetch_c1_bus: got rd=%b addr=%h expected 1/0002", mem_read1, mem_addr1); end
        checks++; if ({bus1.req_ready, bus1.rsp_valid} !== 2'b00) begin errors++; $display("FAIL fetch_c1_hs: got ready=%b valid=%b expected 0/0", bus1.req_ready, bus1.rsp_valid); end
        tick();
        checks++; if ({mem_read1, mem_addr1} !== {1'b1, 13'd3}) begin errors++; $display("FAIL fetch_c2_bus: got rd=%b addr=%h expected 1/0003", mem_read1, mem_addr1); end
        tick();
        checks++; if (bus1.rsp_valid !== 1'b1) begin errors++; $display("FAIL fetch_c3_valid: got %b expected 1", bus1.rsp_valid); end
        checks++; if (bus1.rsp_data !== 16'h0966) begin errors++; $display("FAIL fetch_data: got %h expected 0966", bus1.rsp_data); end
        checks++; if (bus1.rsp_opcode !== 3'd6) begin errors++; $display("FAIL fetch_opcode: got %0d expected 6", bus1.rsp_opcode); end
        checks++; if (bus1.rsp_oprnd !== 13'd300) begin errors++; $display("FAIL fetch_oprnd: got %0d expected 300", bus1.rsp_oprnd); end
        checks++; if (mem_read1 !== 1'b0) begin errors++; $display("FAIL fetch_c3_rd: got %b expected 0", mem_read1); end
        tick();
        checks++; if ({bus1.rsp_valid, bus1.req_ready} !== 2'b01) begin errors++; $display("FAIL fetch_c4_hs: got valid=%b ready=%b expected 0/1", bus1.rsp_valid, bus1.req_ready); end
        checks++; if (bus1.rsp_data !== 16'h0966) begin errors++; $display("FAIL fetch_hold: got %h expected 0966", bus1.rsp_data); end
    endtask

    task automatic test_write_read();
        int e0;
        e0 = wr_edges1;
        issue1(2'b01, 13'd300, 8'h55);
        checks++; if ({mem_write1, mem_read1, mem_addr1} !== {2'b00, 13'd300}) begin errors++; $display("FAIL wr_setup: got wr=%b rd=%b addr=%0d expected 0/0/300", mem_write1, mem_read1, mem_addr1); end
        tick();
        checks++; if (mem_write1 !== 1'b1) begin errors++; $display("FAIL wr_strobe: got %b expected 1", mem_write1); end
        tick();
        checks++; if ({mem_write1, mem_addr1} !== {1'b0, 13'd300}) begin errors++; $display("FAIL wr_hold: got wr=%b addr=%0d expected 0/300", mem_write1, mem_addr1); end
        tick();
        checks++; if ({bus1.rsp_valid, bus1.rsp_data} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL wr_ack: got valid=%b data=%h expected 1/0000", bus1.rsp_valid, bus1.rsp_data); end
        tick();
        checks++; if (raom1[300] !== 8'h55) begin errors++; $display("FAIL wr_mem: got %h expected 55", raom1[300]); end
        checks++; if (wr_edges1 - e0 !== 1) begin errors++; $display("FAIL wr_edges: got %0d expected 1", wr_edges1 - e0); end
        issue1(2'b00, 13'd300, 8'h00);
        checks++; if ({mem_read1, mem_addr1} !== {1'b1, 13'd300}) begin errors++; $display("FAIL rd_c1: got rd=%b addr=%0d expected 1/300", mem_read1, mem_addr1); end
        tick();
        checks++; if ({bus1.rsp_valid, bus1.rsp_data} !== {1'b1, 16'h0055}) begin errors++; $display("FAIL rd_rsp: got valid=%b data=%h expected 1/0055", bus1.rsp_valid, bus1.rsp_data); end
        tick();
    endtask

    task automatic test_wrap();
        poke(1'b0, 13'h1FFF, 8'hA5);
        poke(1'b0, 13'h0000, 8'h3C);
        issue1(2'b10, 13'h1FFF, 8'h00);
        checks++; if (mem_addr1 !== 13'h1FFF) begin errors++; $display("FAIL wrap_a0: got %h expected 1fff", mem_addr1); end
        tick();
        checks++; if (mem_addr1 !== 13'h0000) begin errors++; $display("FAIL wrap_a1: got %h expected 0000", mem_addr1); end
        tick();
        checks++; if ({bus1.rsp_valid, bus1.rsp_data} !== {1'b1, 16'hA53C}) begin errors++; $display("FAIL wrap_rsp: got valid=%b data=%h expected 1/a53c", bus1.rsp_valid, bus1.rsp_data); end
        checks++; if ({bus1.rsp_opcode, bus1.rsp_oprnd} !== {3'd4, 13'h14A7}) begin errors++; $display("FAIL wrap_split: got op=%h oprnd=%h expected 4/14a7", bus1.rsp_opcode, bus1.rsp_oprnd); end
        tick();
    endtask

    task automatic test_reserved();
        issue1(2'b11, 13'd5, 8'h00);
        checks++; if ({bus1.rsp_valid, bus1.rsp_data, mem_read1, mem_write1} !== {1'b1, 16'h0000, 2'b00}) begin errors++; $display("FAIL reserved: got valid=%b data=%h rd=%b wr=%b expected 1/0000/0/0", bus1.rsp_valid, bus1.rsp_data, mem_read1, mem_write1); end
        tick();
        checks++; if (bus1.req_ready !== 1'b1) begin errors++; $display("FAIL reserved_ready: got %b expected 1", bus1.req_ready); end
    endtask

    task automatic test_rst_fetch();
        int seen;
        poke(1'b0, 13'd10, 8'h12);
        poke(1'b0, 13'd11, 8'h34);
        issue1(2'b10, 13'd10, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({bus1.req_ready, bus1.rsp_valid, mem_read1, mem_addr1, bus1.rsp_data} !== {1'b1, 1'b0, 1'b0, 13'd0, 16'h0}) begin errors++; $display("FAIL rstf_vals: got ready=%b valid=%b rd=%b addr=%h data=%h expected 1/0/0/0000/0000", bus1.req_ready, bus1.rsp_valid, mem_read1, mem_addr1, bus1.rsp_data); end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus1.rsp_valid) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstf_no_rsp: got %0d pulses expected 0", seen); end
        issue1(2'b10, 13'd10, 8'h00);
        tick();
        tick();
        checks++; if ({bus1.rsp_valid, bus1.rsp_data, bus1.rsp_opcode, bus1.rsp_oprnd} !== {1'b1, 16'h1234, 3'd4, 13'h0246}) begin errors++; $display("FAIL rstf_refetch: got valid=%b data=%h op=%h oprnd=%h expected 1/1234/4/0246", bus1.rsp_valid, bus1.rsp_data, bus1.rsp_opcode, bus1.rsp_oprnd); end
        tick();
    endtask

    task automatic test_rst_write();
        int e0;
        poke(1'b0, 13'd500, 8'hEE);
        e0 = wr_edges1;
        issue1(2'b01, 13'd500, 8'h77);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({mem_write1, bus1.req_ready} !== 2'b01) begin errors++; $display("FAIL rstw_vals: got wr=%b ready=%b expected 0/1", mem_write1, bus1.req_ready); end
        tick();
        tick();
        checks++; if (raom1[500] !== 8'hEE) begin errors++; $display("FAIL rstw_mem: got %h expected ee", raom1[500]); end
        checks++; if (wr_edges1 - e0 !== 0) begin errors++; $display("FAIL rstw_edges: got %0d expected 0", wr_edges1 - e0); end
    endtask

    task automatic test_back_to_back();
        poke(1'b1, 13'd7, 8'hC8);
        poke(1'b1, 13'd8, 8'h5A);
        bus3.req_valid = 1'b1;
        bus3.req_op    = 2'b00;
        bus3.req_addr  = 13'd7;
        bus3.req_wdata = 8'h00;
        tick();
        bus3.req_addr  = 13'd8;
        for (int c = 1; c <= 3; c++) begin
            checks++; if ({mem_read3, mem_addr3, bus3.req_ready, bus3.rsp_valid} !== {1'b1, 13'd7, 2'b00}) begin errors++; $display("FAIL b2b_busy c%0d: got rd=%b addr=%0d ready=%b valid=%b expected 1/7/0/0", c, mem_read3, mem_addr3, bus3.req_ready, bus3.rsp_valid); end
            tick();
        end
        checks++; if ({bus3.rsp_valid, bus3.rsp_data, mem_read3, bus3.req_ready} !== {1'b1, 16'h00C8, 2'b00}) begin errors++; $display("FAIL b2b_rsp1: got valid=%b data=%h rd=%b ready=%b expected 1/00c8/0/0", bus3.rsp_valid, bus3.rsp_data, mem_read3, bus3.req_ready); end
        tick();
        checks++; if ({bus3.req_ready, bus3.rsp_valid, mem_read3} !== 3'b100) begin errors++; $display("FAIL b2b_idle: got ready=%b valid=%b rd=%b expected 1/0/0", bus3.req_ready, bus3.rsp_valid, mem_read3); end
        tick();
        bus3.req_valid = 1'b0;
        checks++; if ({mem_read3, mem_addr3} !== {1'b1, 13'd8}) begin errors++; $display("FAIL b2b_second: got rd=%b addr=%0d expected 1/8", mem_read3, mem_addr3); end
        tick();
        tick();
        tick();
        checks++; if ({bus3.rsp_valid, bus3.rsp_data} !== {1'b1, 16'h005A}) begin errors++; $display("FAIL b2b_rsp2: got valid=%b data=%h expected 1/005a", bus3.rsp_valid, bus3.rsp_data); end
        tick();
    endtask

    task automatic test_bus_rules();
        checks++; if (overlap !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d cycles expected 0", overlap); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wr_edges1 = 0;
        wr_edges3 = 0;
        overlap = 0;
        mw_prev1 = 1'b0;
        mw_prev3 = 1'b0;
        pre_we1 = 1'b0;
        pre_we3 = 1'b0;
        pre_addr = 13'd0;
        pre_data = 8'h00;
        rst = 1'b1;
        bus1.req_valid = 1'b0;
        bus1.req_op    = 2'b00;
        bus1.req_addr  = 13'd0;
        bus1.req_wdata = 8'h00;
        bus3.req_valid = 1'b0;
        bus3.req_op    = 2'b00;
        bus3.req_addr  = 13'd0;
        bus3.req_wdata = 8'h00;

        test_reset();
        test_fetch();
        test_write_read();
        test_wrap();
        test_reserved();
        test_rst_fetch();
        test_rst_write();
        test_back_to_back();
        test_bus_rules();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
